factor_sieve_sampler: RTL and testbench
=======================================

FACTOR_SIEVE_SAMPLER -- requirements
Module: factor_sieve_sampler

Interface
REQ-001 SHALL have parameter N_W, default 64, meaning bit width of semiprime N (even, >= 8).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of proposal counter and limit.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_start  input  1  start request, level-sampled in IDLE.
REQ-006 SHALL have port i_N  input  N_W  semiprime, sampled in LOAD.
REQ-007 SHALL have port i_max_count  input  CNT_W  proposal limit, sampled in LOAD.
REQ-008 SHALL have port i_pbit  input  N_W/2+1  external p-bit sample vector, sampled in PROPOSE.
REQ-009 SHALL have port i_accept_rand  input  1  random bit permitting uphill moves, sampled in EVAL.
REQ-010 SHALL have ports o_busy, o_done, o_found, o_target_sel (0=X, 1=Y)  output  1 each.
REQ-011 SHALL have ports o_X, o_Y  output  N_W/2+1 each, and o_count  output  CNT_W.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, PROPOSE, EVAL, DONE.
REQ-013 SHALL go IDLE->LOAD when i_start=1; i_start is ignored in every other state.
REQ-014 SHALL in LOAD latch N and limit, compute L = index of MSB of N plus 1, H = ceil(L/2)+1, set X=Y=2^H-1, count=0, target=X, E_cur=|N - X*Y|.
REQ-015 SHALL go LOAD->DONE with o_found=0 when N[0]=0, N<9, or i_max_count=0; otherwise LOAD->PROPOSE.
REQ-016 SHALL in PROPOSE register candidate C = {i_pbit[H-1:1], 1'b1}, bits at positions >= H forced to 0, then go to EVAL.
REQ-017 SHALL in EVAL compute P = C*(non-target factor) at full width N_W+2, and E_new = |N - P|.
REQ-018 SHALL reject C when C=1, and additionally when sieve rules under REQ-029 apply.
REQ-019 SHALL accept a non-rejected C when E_new <= E_cur or i_accept_rand=1; acceptance writes C into the target factor and sets E_cur=E_new.
REQ-020 SHALL, on every EVAL exit, increment count and toggle target, whether C was accepted or rejected.
REQ-021 SHALL go EVAL->DONE with o_found=1 when C is accepted and P=N; the factor update and count increment still occur.
REQ-022 SHALL otherwise go EVAL->DONE with o_found=0 when the incremented count equals the limit; else go EVAL->PROPOSE.
REQ-023 SHALL give found-match priority over the limit when both occur in the same EVAL.
REQ-024 SHALL hold o_done=1 in DONE until i_start=0 is sampled, then go to IDLE; o_X, o_Y, o_count and o_found hold until the next LOAD.
REQ-025 SHALL drive o_busy=1 in LOAD, PROPOSE and EVAL only; each proposal takes 2 cycles.

Reset
REQ-026 SHALL, while rst=1 at any time including mid-run, force state IDLE, o_X=o_Y=0, o_count=0, o_done=o_found=o_busy=0, o_target_sel=0 and E_cur=0.
REQ-027 SHALL on rst deassertion remain in IDLE until i_start=1 is sampled.

Configuration
REQ-028 SHALL compile the candidate sieve only when macro FACTOR_SIEVE_EN is defined.
REQ-029 SHALL, with FACTOR_SIEVE_EN defined, additionally reject C when C mod 3 = 0 and C != 3, or C mod 5 = 0 and C != 5.
REQ-030 SHALL, without FACTOR_SIEVE_EN, apply only the C=1 rejection; no sieve logic is synthesised.

Verification
REQ-031 SHALL cover: N=15, limit=8; i_start sampled at edge 0; i_pbit=3'b011 then 3'b101 -> o_done=1 after edge 5, o_found=1, o_X=3, o_Y=5, o_count=2.
REQ-032 SHALL cover: N=143, limit=4, i_pbit=0 throughout -> o_found=0, o_count=4, o_X=o_Y=31.
REQ-033 SHALL cover: N=35; first PROPOSE gives C=9 with i_accept_rand=0 -> with FACTOR_SIEVE_EN, X stays 15 and count=1; without it, X=9 (E 190->100).
REQ-034 SHALL cover: N=36, or i_max_count=0 -> DONE directly after LOAD, o_found=0, o_count=0.
REQ-035 SHALL cover: rst pulsed during EVAL -> all outputs are 0 in the same cycle and the FSM stays in IDLE until i_start.
REQ-036 SHALL cover: i_start held at 1 through DONE -> o_done stays 1 with no restart until i_start=0.

Source files
------------

// File: rtl/factor_sieve_sampler.sv
// Stochastic semiprime factoring sampler: proposes odd candidates from an external p-bit vector
// and accepts them by an energy |N - X*Y| rule. Optional candidate sieve: define FACTOR_SIEVE_EN.
module factor_sieve_sampler #(
    parameter int N_W   = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [N_W-1:0]   i_N,
    input  logic [CNT_W-1:0] i_max_count,
    input  logic [N_W/2:0]   i_pbit,
    input  logic             i_accept_rand,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_found,
    output logic             o_target_sel,
    output logic [N_W/2:0]   o_X,
    output logic [N_W/2:0]   o_Y,
    output logic [CNT_W-1:0] o_count
);
    localparam int FW = N_W/2 + 1;
    localparam int PW = N_W + 2;
    localparam int LW = $clog2(N_W + 2);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PROPOSE, S_EVAL, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [N_W-1:0]   r_N;
    logic [CNT_W-1:0] r_limit, r_count;
    logic [FW-1:0]    r_mask, r_X, r_Y, r_C;
    logic [PW-1:0]    r_E;
    logic             r_tsel, r_found;

    logic [LW-1:0]    w_L, w_H;
    logic [FW-1:0]    w_mask, w_cand, w_op_a, w_op_b;
    logic [PW-1:0]    w_n_ext, w_P, w_E;
    logic             w_rej, w_acc, w_hit, w_load_abort;
    logic [CNT_W-1:0] w_cnt_inc;

    // Bit length of N and the all-ones starting factor of width H = ceil(L/2)+1.
    always_comb begin
        w_L = '0;
        for (int i = 0; i < N_W; i++)
            if (i_N[i]) w_L = LW'(i + 1);
        w_H = ((w_L + LW'(1)) >> 1) + LW'(1);
        w_mask = '0;
        for (int i = 0; i < FW; i++)
            w_mask[i] = (LW'(i) < w_H);
    end

    // One multiplier serves both the initial energy in LOAD and the proposal energy in EVAL.
    assign w_op_a  = (r_state == S_EVAL) ? r_C : w_mask;
    assign w_op_b  = (r_state == S_EVAL) ? (r_tsel ? r_X : r_Y) : w_mask;
    assign w_n_ext = (r_state == S_EVAL) ? {2'b00, r_N} : {2'b00, i_N};
    assign w_P     = PW'(w_op_a) * PW'(w_op_b);
    assign w_E     = (w_n_ext >= w_P) ? (w_n_ext - w_P) : (w_P - w_n_ext);

    assign w_cand  = (i_pbit & r_mask) | FW'(1);

`ifdef FACTOR_SIEVE_EN
    assign w_rej = (r_C == FW'(1))
                || (((r_C % FW'(3)) == '0) && (r_C != FW'(3)))
                || (((r_C % FW'(5)) == '0) && (r_C != FW'(5)));
`else
    assign w_rej = (r_C == FW'(1));
`endif

    assign w_acc        = !w_rej && ((w_E <= r_E) || i_accept_rand);
    assign w_hit        = w_acc && (w_P == {2'b00, r_N});
    assign w_cnt_inc    = r_count + CNT_W'(1);
    assign w_load_abort = !i_N[0] || (i_N < N_W'(9)) || (i_max_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_LOAD;
            S_LOAD:    w_next = w_load_abort ? S_DONE : S_PROPOSE;
            S_PROPOSE: w_next = S_EVAL;
            S_EVAL:    w_next = (w_hit || (w_cnt_inc == r_limit)) ? S_DONE : S_PROPOSE;
            S_DONE:    if (!i_start) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_N     <= '0;
            r_limit <= '0;
            r_count <= '0;
            r_mask  <= '0;
            r_X     <= '0;
            r_Y     <= '0;
            r_C     <= '0;
            r_E     <= '0;
            r_tsel  <= 1'b0;
            r_found <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_N     <= i_N;
                    r_limit <= i_max_count;
                    r_mask  <= w_mask;
                    r_X     <= w_mask;
                    r_Y     <= w_mask;
                    r_E     <= w_E;
                    r_count <= '0;
                    r_tsel  <= 1'b0;
                    r_found <= 1'b0;
                end
                S_PROPOSE: r_C <= w_cand;
                S_EVAL: begin
                    if (w_acc) begin
                        if (r_tsel) r_Y <= r_C;
                        else        r_X <= r_C;
                        r_E <= w_E;
                    end
                    if (w_hit) r_found <= 1'b1;
                    r_count <= w_cnt_inc;
                    r_tsel  <= ~r_tsel;
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (r_state == S_LOAD) || (r_state == S_PROPOSE) || (r_state == S_EVAL);
    assign o_done       = (r_state == S_DONE);
    assign o_found      = r_found;
    assign o_target_sel = r_tsel;
    assign o_X          = r_X;
    assign o_Y          = r_Y;
    assign o_count      = r_count;
endmodule

// File: tb/tb_factor_sieve_sampler.sv
// Scoreboard bench for factor_sieve_sampler: jobs push expected results, a negedge monitor
// checks them when o_done rises.
module tb_factor_sieve_sampler;
    localparam int N_W   = 64;
    localparam int CNT_W = 32;
    localparam int FW    = N_W/2 + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [N_W-1:0]   i_N;
    logic [CNT_W-1:0] i_max_count;
    logic [FW-1:0]    i_pbit;
    logic             i_accept_rand;
    logic             o_busy, o_done, o_found, o_target_sel;
    logic [FW-1:0]    o_X, o_Y;
    logic [CNT_W-1:0] o_count;

    factor_sieve_sampler #(.N_W(N_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_N(i_N), .i_max_count(i_max_count),
        .i_pbit(i_pbit), .i_accept_rand(i_accept_rand), .o_busy(o_busy), .o_done(o_done),
        .o_found(o_found), .o_target_sel(o_target_sel), .o_X(o_X), .o_Y(o_Y), .o_count(o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             found;
        logic [FW-1:0]    x, y;
        logic [CNT_W-1:0] cnt;
        int               lat;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          e;
    int            total = 0, bad = 0;
    int            cyc = 0, t0 = 0;
    logic          prev_done = 1'b0;
    logic [FW-1:0] pb_v[8];
    logic          ar_v[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (o_done && !prev_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'(o_done), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("found", 64'(o_found), 64'(e.found));
                chk("X", 64'(o_X), 64'(e.x));
                chk("Y", 64'(o_Y), 64'(e.y));
                chk("count", 64'(o_count), 64'(e.cnt));
                chk("target_sel", 64'(o_target_sel), 64'(e.cnt[0]));
                chk("busy_in_done", 64'(o_busy), 64'(0));
                if (e.lat >= 0) chk("latency", 64'(cyc - t0), 64'(e.lat));
            end
        end
        prev_done <= o_done;
    end

    // Issues one job; pb_v/ar_v hold per-proposal inputs, hold>0 keeps i_start high through DONE.
    task automatic run_job(input logic [N_W-1:0] n, input logic [CNT_W-1:0] lim, input int np,
                           input logic fnd, input logic [FW-1:0] ex, input logic [FW-1:0] ey,
                           input logic [CNT_W-1:0] ecnt, input int lat, input int hold);
        exp_t x;
        int   w;
        x.found = fnd; x.x = ex; x.y = ey; x.cnt = ecnt; x.lat = lat;
        sb_q.push_back(x);
        @(negedge clk);
        i_N = n; i_max_count = lim; i_start = 1'b1; i_pbit = pb_v[0]; i_accept_rand = ar_v[0];
        @(posedge clk); #1;
        t0 = cyc;
        i_start = (hold > 0);
        for (int k = 0; k < np; k++) begin
            @(posedge clk); #1;
            i_pbit = pb_v[k]; i_accept_rand = ar_v[k];
            @(posedge clk);
        end
        w = 0;
        #1;
        while (!o_done && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("done_seen", 64'(o_done), 64'(1));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_done", 64'(o_done), 64'(1));
            chk("hold_busy", 64'(o_busy), 64'(0));
        end
        i_start = 1'b0;
        @(posedge clk); #1;
        chk("done_clear", 64'(o_done), 64'(0));
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_N = '0; i_max_count = '0; i_pbit = '0; i_accept_rand = 1'b0;
        for (int i = 0; i < 8; i++) begin pb_v[i] = '0; ar_v[i] = 1'b0; end
        #12;
        chk("rst_X", 64'(o_X), 64'(0));
        chk("rst_Y", 64'(o_Y), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("idle_busy", 64'(o_busy), 64'(0));

        // N=15: C=3 into X (E 34->6), C=5 into Y hits 3*5=15.
        pb_v[0] = 33'd3; pb_v[1] = 33'd5;
        run_job(64'd15, 32'd8, 2, 1'b1, 33'd3, 33'd5, 32'd2, 5, 0);
        // Same with limit 2: match and limit coincide, match wins.
        run_job(64'd15, 32'd2, 2, 1'b1, 33'd3, 33'd5, 32'd2, 5, 0);
        // N=143, p-bits all zero: C=1 always rejected.
        pb_v[0] = '0; pb_v[1] = '0; pb_v[2] = '0; pb_v[3] = '0;
        run_job(64'd143, 32'd4, 4, 1'b0, 33'd31, 33'd31, 32'd4, 9, 0);
        // N=35: C=9, E 190->100; sieve rejects 9.
        pb_v[0] = 33'd8;
`ifdef FACTOR_SIEVE_EN
        run_job(64'd35, 32'd1, 1, 1'b0, 33'd15, 33'd15, 32'd1, 3, 0);
`else
        run_job(64'd35, 32'd1, 1, 1'b0, 33'd9, 33'd15, 32'd1, 3, 0);
`endif
        // Early exits: even N (start held through DONE), limit 0, N below 9.
        run_job(64'd36, 32'd5, 0, 1'b0, 33'd15, 33'd15, 32'd0, 1, 4);
        run_job(64'd15, 32'd0, 0, 1'b0, 33'd7, 33'd7, 32'd0, 1, 0);
        run_job(64'd7, 32'd5, 0, 1'b0, 33'd7, 33'd7, 32'd0, 1, 0);
        // High p-bits above H are masked: 'hF3 -> C=3 for H=3.
        pb_v[0] = 33'hF3;
        run_job(64'd15, 32'd1, 1, 1'b0, 33'd3, 33'd7, 32'd1, 3, 0);

        // Reset pulsed during EVAL.
        @(negedge clk);
        i_N = 64'd143; i_max_count = 32'd10; i_pbit = '0; i_accept_rand = 1'b0; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_busy", 64'(o_busy), 64'(1));
        chk("pre_rst_X", 64'(o_X), 64'(31));
        rst = 1'b1; #1;
        chk("midrst_X", 64'(o_X), 64'(0));
        chk("midrst_Y", 64'(o_Y), 64'(0));
        chk("midrst_busy", 64'(o_busy), 64'(0));
        chk("midrst_count", 64'(o_count), 64'(0));
        chk("midrst_found", 64'(o_found), 64'(0));
        chk("midrst_done", 64'(o_done), 64'(0));
        chk("midrst_tsel", 64'(o_target_sel), 64'(0));
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", 64'(o_busy), 64'(0));
        chk("post_rst_done", 64'(o_done), 64'(0));

        // N=143: X=11 (E 198), Y=3 (E 110), then C=3 into X is uphill (E 134).
        pb_v[0] = 33'd11; pb_v[1] = 33'd3; pb_v[2] = 33'd3;
        ar_v[0] = 1'b0; ar_v[1] = 1'b0; ar_v[2] = 1'b1;
        run_job(64'd143, 32'd3, 3, 1'b0, 33'd3, 33'd3, 32'd3, 7, 0);
        ar_v[2] = 1'b0;
        run_job(64'd143, 32'd3, 3, 1'b0, 33'd11, 33'd3, 32'd3, 7, 0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
